// File: rtl/gate_net_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : gate_net_ctrl_pkg
// Description : Shared types, defaults and helpers for the gate-network
//               inference sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package gate_net_ctrl_pkg;

    localparam int N_IN_DEF  = 49;
    localparam int N_CLS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_e;

    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_SETTLE = SETTLE;
    localparam logic [1:0] c_ST_OUT    = OUT;

    // Label width needed to index n classes; never narrower than one bit.
    function automatic int lbl_w_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_net_infer_ctrl_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : onehot_class_decode
// Description : Combinational one-hot class decoder with ambiguity flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module onehot_class_decode #(
    parameter int N_CLS = 2,
    parameter int LBL_W = 1
) (
    input  logic [N_CLS-1:0] net_out,
    output logic [LBL_W-1:0] cls,
    output logic             ambig
);

    int               w_pop;
    logic [LBL_W-1:0] w_idx;

    // Scan from the top so the last hit written is the lowest set index.
    always_comb begin
        w_pop = 0;
        w_idx = '0;
        for (int i = N_CLS - 1; i >= 0; i--) begin
            if (net_out[i]) begin
                w_pop = w_pop + 1;
                w_idx = LBL_W'(i);
            end
        end
    end

    assign cls   = w_idx;
    assign ambig = (w_pop != 1);

endmodule
`default_nettype wire

// File: rtl/gate_net_infer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : gate_net_infer_ctrl
// Description : Sample sequencer and accuracy statistics for a combinational
//               gate-network classifier.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module gate_net_infer_ctrl
    import gate_net_ctrl_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int N_CLS         = N_CLS_DEF,
    parameter int LBL_W         = lbl_w_for(N_CLS_DEF),
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_IN-1:0]   s_bits,
    input  logic [LBL_W-1:0]  s_label,
    output logic [N_IN-1:0]   net_in,
    input  logic [N_CLS-1:0]  net_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LBL_W-1:0]  m_class,
    output logic              m_ambig,
    output logic              m_correct,
    input  logic              clr_stats,
    input  logic [CNT_W-1:0]  batch_len,
    output logic              batch_done,
    output logic [CNT_W-1:0]  cnt_total,
    output logic [CNT_W-1:0]  cnt_correct,
    output logic [CNT_W-1:0]  cnt_ambig,
    output logic              busy
);

    localparam logic [7:0]       c_TIMER_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [7:0]       r_timer;
    logic [N_IN-1:0]  r_net_in;
    logic [LBL_W-1:0] r_label;
    logic             r_m_valid;
    logic [LBL_W-1:0] r_m_class;
    logic             r_m_ambig;
    logic             r_m_correct;
    logic [CNT_W-1:0] r_cnt_total;
    logic [CNT_W-1:0] r_cnt_correct;
    logic [CNT_W-1:0] r_cnt_ambig;
    logic             r_batch_armed;
    logic             r_batch_done;

    logic [LBL_W-1:0] w_cls;
    logic             w_ambig;
    logic             w_lbl_ok;
    logic             w_hs;
    logic [CNT_W-1:0] w_total_inc;
    logic             w_batch_hit;

    onehot_class_decode #(
        .N_CLS (N_CLS),
        .LBL_W (LBL_W)
    ) u_decode (
        .net_out (net_out),
        .cls     (w_cls),
        .ambig   (w_ambig)
    );

    assign w_lbl_ok    = (int'(r_label) < N_CLS);
    assign w_hs        = (r_state == c_ST_OUT) && m_ready;
    assign w_total_inc = r_cnt_total + 1'b1;

    // Only a real increment can land on batch_len, so a saturated total stays quiet.
    assign w_batch_hit = w_hs && !clr_stats && r_batch_armed && (batch_len != '0) &&
                         (r_cnt_total != c_CNT_MAX) && (w_total_inc == batch_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_net_in    <= '0;
            r_label     <= '0;
            r_m_valid   <= 1'b0;
            r_m_class   <= '0;
            r_m_ambig   <= 1'b0;
            r_m_correct <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (s_valid) begin
                        r_net_in <= s_bits;
                        r_label  <= s_label;
                        r_timer  <= c_TIMER_INIT;
                        r_state  <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_timer == 8'd0) begin
                        r_m_class   <= w_cls;
                        r_m_ambig   <= w_ambig;
                        r_m_correct <= !w_ambig && w_lbl_ok && (w_cls == r_label);
                        r_m_valid   <= 1'b1;
                        r_state     <= c_ST_OUT;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                c_ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_total   <= '0;
            r_cnt_correct <= '0;
            r_cnt_ambig   <= '0;
            r_batch_armed <= 1'b1;
            r_batch_done  <= 1'b0;
        end else begin
            r_batch_done <= w_batch_hit;
            if (clr_stats) begin
                r_cnt_total   <= '0;
                r_cnt_correct <= '0;
                r_cnt_ambig   <= '0;
                r_batch_armed <= 1'b1;
            end else begin
                if (w_batch_hit) begin
                    r_batch_armed <= 1'b0;
                end
                if (w_hs) begin
                    if (r_cnt_total != c_CNT_MAX) begin
                        r_cnt_total <= w_total_inc;
                    end
                    if (r_m_correct && (r_cnt_correct != c_CNT_MAX)) begin
                        r_cnt_correct <= r_cnt_correct + 1'b1;
                    end
                    if (r_m_ambig && (r_cnt_ambig != c_CNT_MAX)) begin
                        r_cnt_ambig <= r_cnt_ambig + 1'b1;
                    end
                end
            end
        end
    end

    assign s_ready     = (r_state == c_ST_IDLE);
    assign busy        = (r_state != c_ST_IDLE);
    assign net_in      = r_net_in;
    assign m_valid     = r_m_valid;
    assign m_class     = r_m_class;
    assign m_ambig     = r_m_ambig;
    assign m_correct   = r_m_correct;
    assign cnt_total   = r_cnt_total;
    assign cnt_correct = r_cnt_correct;
    assign cnt_ambig   = r_cnt_ambig;
    assign batch_done  = r_batch_done;

endmodule
`default_nettype wire

// File: tb/tb_gate_net_infer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_gate_net_infer_ctrl
// Description : Directed, table-driven bench for gate_net_infer_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_gate_net_infer_ctrl;

    localparam int N_IN   = 49;
    localparam int N_CLS  = 2;
    localparam int LBL_W  = 1;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [N_IN-1:0]   s_bits;
    logic [LBL_W-1:0]  s_label;
    logic [N_IN-1:0]   net_in;
    logic [N_CLS-1:0]  net_out;
    logic              m_valid;
    logic              m_ready;
    logic [LBL_W-1:0]  m_class;
    logic              m_ambig;
    logic              m_correct;
    logic              clr_stats;
    logic [CNT_W-1:0]  batch_len;
    logic              batch_done;
    logic [CNT_W-1:0]  cnt_total;
    logic [CNT_W-1:0]  cnt_correct;
    logic [CNT_W-1:0]  cnt_ambig;
    logic              busy;

    gate_net_infer_ctrl #(
        .N_IN          (N_IN),
        .N_CLS         (N_CLS),
        .LBL_W         (LBL_W),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_bits      (s_bits),
        .s_label     (s_label),
        .net_in      (net_in),
        .net_out     (net_out),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_class     (m_class),
        .m_ambig     (m_ambig),
        .m_correct   (m_correct),
        .clr_stats   (clr_stats),
        .batch_len   (batch_len),
        .batch_done  (batch_done),
        .cnt_total   (cnt_total),
        .cnt_correct (cnt_correct),
        .cnt_ambig   (cnt_ambig),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_IN-1:0]  bits;
        logic [LBL_W-1:0] lbl;
        logic [N_CLS-1:0] nout;
        logic [LBL_W-1:0] e_cls;
        logic             e_amb;
        logic             e_cor;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_err    = 0;
    int exp_total   = 0;
    int exp_correct = 0;
    int exp_ambig   = 0;
    logic last_bd;
    logic [N_IN-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one sample, then wait (bounded) for the result and check it.
    task automatic issue(input logic [N_IN-1:0] bits, input logic [LBL_W-1:0] lbl,
                         input logic [N_CLS-1:0] nout, input logic [LBL_W-1:0] e_cls,
                         input logic e_amb, input logic e_cor, input string tag);
        int lat;
        s_valid = 1'b1;
        s_bits  = bits;
        s_label = lbl;
        net_out = nout;
        tick();
        s_valid = 1'b0;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        chk({tag, " s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, " net_in"}, 64'(net_in), 64'(bits));
        lat = 0;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(SETTLE));
        chk({tag, " m_class"}, 64'(m_class), 64'(e_cls));
        chk({tag, " m_ambig"}, 64'(m_ambig), 64'(e_amb));
        chk({tag, " m_correct"}, 64'(m_correct), 64'(e_cor));
    endtask

    task automatic handshake(input logic cor, input logic amb, input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        exp_total++;
        exp_correct += int'(cor);
        exp_ambig   += int'(amb);
        last_bd = batch_done;
        chk({tag, " m_valid low"}, 64'(m_valid), 64'd0);
        chk({tag, " cnt_total"}, 64'(cnt_total), 64'(exp_total));
        chk({tag, " cnt_correct"}, 64'(cnt_correct), 64'(exp_correct));
        chk({tag, " cnt_ambig"}, 64'(cnt_ambig), 64'(exp_ambig));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " s_ready"}, 64'(s_ready), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " net_in"}, 64'(net_in), 64'd0);
        chk({tag, " m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, " cnt_total"}, 64'(cnt_total), 64'd0);
        chk({tag, " cnt_correct"}, 64'(cnt_correct), 64'd0);
        chk({tag, " cnt_ambig"}, 64'(cnt_ambig), 64'd0);
        chk({tag, " batch_done"}, 64'(batch_done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{49'h1_0000_0000_4000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{49'h0_00F0_0000_0001, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{49'h1_FFFF_FFFF_FFFF, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{49'h0_1234_5678_9ABC, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{49'h1_5555_AAAA_5555, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{49'h0_0000_0000_0002, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{49'h0_8000_0000_0000, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; s_valid = 1'b0; s_bits = '0; s_label = '0;
        net_out = '0; m_ready = 1'b0; clr_stats = 1'b0; batch_len = '0;
        last_bd = 1'b0;
        tick(); tick();
        chk_reset_state("reset");
        chk("reset m_class", 64'(m_class), 64'd0);
        chk("reset m_ambig", 64'(m_ambig), 64'd0);
        chk("reset m_correct", 64'(m_correct), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].bits, vecs[i].lbl, vecs[i].nout, vecs[i].e_cls,
                  vecs[i].e_amb, vecs[i].e_cor, $sformatf("vec%0d", i));
            handshake(vecs[i].e_cor, vecs[i].e_amb, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d net_in kept", i), 64'(net_in), 64'(vecs[i].bits));
        end

        // Backpressure: result held, new samples and net_out changes ignored.
        held = 49'h0_0F0F_0F0F_0F0F;
        issue(held, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, "bp");
        s_valid = 1'b1;
        s_bits  = 49'h1_AAAA_AAAA_AAAA;
        s_label = 1'b0;
        net_out = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp m_valid", 64'(m_valid), 64'd1);
            chk("bp m_class", 64'(m_class), 64'd1);
            chk("bp s_ready", 64'(s_ready), 64'd0);
            chk("bp net_in", 64'(net_in), 64'(held));
            chk("bp cnt_total", 64'(cnt_total), 64'(exp_total));
        end
        s_valid = 1'b0;
        chk("bp m_correct", 64'(m_correct), 64'd1);
        handshake(1'b1, 1'b0, "bp");

        // Batch tracking.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        exp_total = 0; exp_correct = 0; exp_ambig = 0;
        chk("clr cnt_total", 64'(cnt_total), 64'd0);
        chk("clr cnt_correct", 64'(cnt_correct), 64'd0);
        batch_len = 16'd3;
        for (int k = 0; k < 4; k++) begin
            issue(49'(k + 5), 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, $sformatf("batch%0d", k));
            handshake(1'b1, 1'b0, $sformatf("batch%0d", k));
            chk($sformatf("batch%0d pulse", k), 64'(last_bd), 64'(k == 2));
            tick();
            chk($sformatf("batch%0d pulse end", k), 64'(batch_done), 64'd0);
        end
        chk("batch total", 64'(cnt_total), 64'd4);
        batch_len = '0;

        // clr_stats coincident with a handshake: clear wins.
        issue(49'h1_0000_0000_0001, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "clrhs");
        m_ready   = 1'b1;
        clr_stats = 1'b1;
        tick();
        m_ready   = 1'b0;
        clr_stats = 1'b0;
        exp_total = 0; exp_correct = 0; exp_ambig = 0;
        chk("clrhs m_valid", 64'(m_valid), 64'd0);
        chk("clrhs busy", 64'(busy), 64'd0);
        chk("clrhs cnt_total", 64'(cnt_total), 64'd0);
        chk("clrhs cnt_ambig", 64'(cnt_ambig), 64'd0);
        issue(49'h0_0000_0000_0003, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, "after_clr");
        handshake(1'b1, 1'b0, "after_clr");

        // Reset during SETTLE.
        s_valid = 1'b1;
        s_bits  = 49'h1_2345_6789_ABCD;
        s_label = 1'b0;
        net_out = 2'b01;
        tick();
        s_valid = 1'b0;
        chk("rst_settle pre m_valid", 64'(m_valid), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_total = 0; exp_correct = 0; exp_ambig = 0;
        chk_reset_state("rst_settle");

        // Reset in OUT with a pending result.
        issue(49'h0_0000_0000_00FF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, "pre_rst_out");
        handshake(1'b1, 1'b0, "pre_rst_out");
        issue(49'h0_0000_0000_0F00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, "rst_out");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_total = 0; exp_correct = 0; exp_ambig = 0;
        chk_reset_state("rst_out");
        tick();
        chk("rst_out idle stays", 64'(m_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_net_infer_ctrl.md
Name: gate_net_infer_ctrl

Overview:
- Sequencer for the combinational MNIST gate-network classifier, e.g. the 49-input / 2-class small network.
- Accepts labelled samples on a valid/ready stream and drives the sample onto the network inputs.
- Waits a programmable settle time, captures and decodes the class outputs, then emits a scored result on a valid/ready stream.
- Keeps running accuracy statistics used by the scaling experiments' hardware harness.

Parameters:
- N_IN, 49, width of sample bit vector / network input.
- N_CLS, 2, number of network class outputs (one flag per class).
- LBL_W, 1, label/class index width; must satisfy 2^LBL_W >= N_CLS.
- SETTLE_CYCLES, 2, cycles net_in is held stable before net_out is sampled; legal range 1..255.
- CNT_W, 16, width of statistics counters and batch_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_bits  in  N_IN  sample pixels (bit i drives network input i)
- s_label  in  LBL_W  ground-truth class
- net_in  out  N_IN  registered drive to classifier in_bits
- net_out  in  N_CLS  classifier out_bits
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  LBL_W  decoded class
- m_ambig  out  1  net_out was not one-hot
- m_correct  out  1  not ambiguous and m_class == label
- clr_stats  in  1  synchronous clear of counters
- batch_len  in  CNT_W  samples per batch; 0 = batch tracking off
- batch_done  out  1  one-cycle pulse at end of batch
- cnt_total  out  CNT_W  results handed off
- cnt_correct  out  CNT_W  correct results
- cnt_ambig  out  CNT_W  ambiguous results
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset is honoured in any state, including mid-settle or with m_valid high. A pending result is dropped.
- Reset values:
  - state = IDLE; s_ready = 1; busy = 0.
  - net_in = 0.
  - m_valid = 0; m_class = 0; m_ambig = 0; m_correct = 0.
  - All counters = 0; batch_done = 0.
- IDLE:
  - s_ready = 1.
  - On s_valid && s_ready: net_in <= s_bits, label register <= s_label, timer <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - s_ready = 0; net_in is held constant.
  - timer decrements each cycle. When timer == 0:
    - capture the decode of net_out into m_class, m_ambig, m_correct;
    - set m_valid = 1 and go to OUT.
  - Timing: m_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- OUT:
  - m_valid = 1; m_class, m_ambig and m_correct are stable; s_ready = 0.
  - On m_ready: m_valid <= 0, update counters, go to IDLE.
  - Peak throughput is 1 sample per SETTLE_CYCLES+2 cycles.
- Decode:
  - popcount(net_out) == 1 → m_class = index of the set bit, m_ambig = 0.
  - Otherwise → m_ambig = 1, m_class = lowest set index, or 0 if no bit is set.
  - A label >= N_CLS is always scored incorrect.
- net_in keeps the last sample after completion; it changes only on accept.
- Counters:
  - Updated on the result handshake: cnt_total +1, cnt_correct +m_correct, cnt_ambig +m_ambig.
  - Each counter saturates at 2^CNT_W-1.
- clr_stats:
  - Zeroes all counters on the next edge.
  - If coincident with a handshake, clear wins: counters become 0 and that sample is not counted. The handshake itself still completes.
  - clr_stats does not affect the FSM.
- batch_done:
  - Pulses one cycle, registered, on the edge after a handshake in which the new cnt_total == batch_len.
  - Requires batch_len != 0. It is not re-armed until clr_stats.
  - Saturation never produces a spurious pulse.
- s_bits and s_label are sampled only on accept; changes while busy are ignored.

Decomposition:
- Package gate_net_ctrl_pkg:
  - state enum {IDLE, SETTLE, OUT};
  - default constants N_IN_DEF = 49 and N_CLS_DEF = 2;
  - clog2-based helper for LBL_W.
- Sub-module onehot_class_decode, purely combinational, parameters N_CLS and LBL_W:
  - input net_out;
  - outputs class index and ambig flag.
- FSM, timer and counters live in the top module.

Test Plan:
- Reset, then a single sample: SETTLE_CYCLES = 2, s_bits = 49'h1_0000_0000_4000, label 0, net_out model = 2'b01 → m_valid 2 edges after accept, m_class = 0, m_correct = 1; cnt_total = 1, cnt_correct = 1.
- Ambiguous outputs: net_out = 2'b11 → m_ambig = 1, m_class = 0, m_correct = 0. Then net_out = 2'b00 → m_ambig = 1, m_class = 0; cnt_ambig = 2.
- Backpressure: m_ready held low for 10 cycles → m_valid and outputs stable, s_ready = 0, net_in unchanged, counters unchanged until m_ready is asserted.
- Batch: batch_len = 3, three correct samples → batch_done pulses exactly once, after the third handshake. A fourth sample gives no pulse and cnt_total = 4.
- clr_stats asserted in the same cycle as a handshake → all counters 0 next cycle; the next sample gives cnt_total = 1.
- rst_n low during SETTLE (and again in OUT with m_valid = 1) → next cycle state is IDLE, m_valid = 0, net_in = 0, counters 0, s_ready = 1.
